clusterv_sram_arb: RTL and testbench

CLUSTERV_SRAM_ARB -- requirements
Module: clusterv_sram_arb

---
 rtl/clusterv_pkg.sv | 16 +
 rtl/clusterv_rr_arb2.sv | 37 +++
 rtl/clusterv_sram_arb.sv | 177 +++++++++++++++++
 tb/tb_clusterv_sram_arb.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clusterv_pkg.sv
// Shared definitions for the clusterv SRAM arbiter: FSM state encoding and request helper.
package clusterv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_PORTS = 2;

  function automatic logic port_req(input logic cyc, input logic stb);
    return cyc & stb;
  endfunction

endpackage

// File: rtl/clusterv_rr_arb2.sv
// Two-requester grant selection, round-robin on contention.
// Defining CLUSTERV_SRAM_ARB_FIXED_PRIO_EN makes requester 0 always win instead.
module clusterv_rr_arb2
  import clusterv_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] gnt
);

`ifdef CLUSTERV_SRAM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // One-hot grant; a tie goes to the requester not served last
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
`ifdef CLUSTERV_SRAM_ARB_FIXED_PRIO_EN
        gnt = 2'b01;
`else
        if (last) begin
          gnt = 2'b01;
        end else begin
          gnt = 2'b10;
        end
`endif
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/clusterv_sram_arb.sv
// Two Wishbone target ports sharing one single-cycle SRAM: IDLE -> ACCESS -> ACK per access.
// Optional macro CLUSTERV_SRAM_ARB_FIXED_PRIO_EN selects fixed priority for port 0.
module clusterv_sram_arb
  import clusterv_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       t0_adr,
  input  logic [DW-1:0]     t0_dat_w,
  input  logic [DW/8-1:0]   t0_sel,
  input  logic              t0_we,
  input  logic              t0_cyc,
  input  logic              t0_stb,
  output logic [DW-1:0]     t0_dat_r,
  output logic              t0_ack,
  input  logic [31:0]       t1_adr,
  input  logic [DW-1:0]     t1_dat_w,
  input  logic [DW/8-1:0]   t1_sel,
  input  logic              t1_we,
  input  logic              t1_cyc,
  input  logic              t1_stb,
  output logic [DW-1:0]     t1_dat_r,
  output logic              t1_ack,
  output logic [AW-1:0]     sram_addr,
  output logic              sram_read_en,
  output logic              sram_write_en,
  output logic [DW/8-1:0]   sram_byte_en,
  output logic [DW-1:0]     sram_write_data,
  input  logic [DW-1:0]     sram_read_data
);

  arb_state_e state;
  arb_state_e state_next;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] arb_gnt;
  logic                 gnt_idx;

  logic                 g_req;
  logic                 g_we;
  logic [31:0]          g_adr;
  logic [DW/8-1:0]      g_sel;
  logic [DW-1:0]        g_dat;

  // Only the word-select bits of the bus address reach the SRAM
  logic unused_adr;
  assign unused_adr = ^{t0_adr[31:AW+2], t0_adr[1:0], t1_adr[31:AW+2], t1_adr[1:0]};

  assign req = {port_req(t1_cyc, t1_stb), port_req(t0_cyc, t0_stb)};

`ifdef CLUSTERV_SRAM_ARB_FIXED_PRIO_EN
  clusterv_rr_arb2 u_arb (
    .req  (req),
    .last (1'b0),
    .gnt  (arb_gnt)
  );
`else
  logic last_grant;

  clusterv_rr_arb2 u_arb (
    .req  (req),
    .last (last_grant),
    .gnt  (arb_gnt)
  );

  // Remembers the most recent winner; reset value 1 lets port 0 win the first tie
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (state == IDLE && (|req)) begin
      last_grant <= arb_gnt[1];
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Granted port index, captured when an access is accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_idx <= 1'b0;
    end else if (state == IDLE && (|req)) begin
      gnt_idx <= arb_gnt[1];
    end
  end

  // Select the granted port's request fields
  always_comb begin
    if (gnt_idx) begin
      g_req = req[1];
      g_we  = t1_we;
      g_adr = t1_adr;
      g_sel = t1_sel;
      g_dat = t1_dat_w;
    end else begin
      g_req = req[0];
      g_we  = t0_we;
      g_adr = t0_adr;
      g_sel = t0_sel;
      g_dat = t0_dat_w;
    end
  end

  // Next-state: a dropped request in ACCESS abandons the access without ack
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next = ACCESS;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS: begin
        if (g_req) begin
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SRAM drive in ACCESS, response to the granted port in ACK; everything else held at 0
  always_comb begin
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    sram_addr       = {AW{1'b0}};
    sram_byte_en    = {(DW/8){1'b0}};
    sram_write_data = {DW{1'b0}};
    t0_ack          = 1'b0;
    t1_ack          = 1'b0;
    t0_dat_r        = {DW{1'b0}};
    t1_dat_r        = {DW{1'b0}};
    case (state)
      ACCESS: begin
        if (g_req) begin
          sram_read_en    = ~g_we;
          sram_write_en   = g_we;
          sram_addr       = g_adr[AW+1:2];
          sram_byte_en    = g_sel;
          sram_write_data = g_dat;
        end else begin
          sram_read_en    = 1'b0;
          sram_write_en   = 1'b0;
        end
      end
      ACK: begin
        if (gnt_idx) begin
          t1_ack   = 1'b1;
          t1_dat_r = sram_read_data;
        end else begin
          t0_ack   = 1'b1;
          t0_dat_r = sram_read_data;
        end
      end
      default: begin
        sram_read_en  = 1'b0;
        sram_write_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_clusterv_sram_arb.sv
// Bench for clusterv_sram_arb: directed vector table, contention/reset sequences,
// and random traffic against a transaction-timeline reference model.
module tb_clusterv_sram_arb;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } port_t;

  // {read_en, write_en, addr, byte_en, write_data, t0_ack, t1_ack, t0_dat_r, t1_dat_r}
  typedef logic [111:0] outv_t;

  typedef struct {
    port_t p0;
    port_t p1;
    outv_t exp;
  } vec_t;

  localparam port_t NP = '0;
  localparam outv_t ZERO = '0;

  logic        clock;
  logic        reset_n;
  logic [31:0] t0_adr, t1_adr;
  logic [31:0] t0_dat_w, t1_dat_w;
  logic [3:0]  t0_sel, t1_sel;
  logic        t0_we, t0_cyc, t0_stb, t1_we, t1_cyc, t1_stb;
  logic [31:0] t0_dat_r, t1_dat_r;
  logic        t0_ack, t1_ack;
  logic [7:0]  sram_addr;
  logic        sram_read_en, sram_write_en;
  logic [3:0]  sram_byte_en;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  int n_chk = 0;
  int n_bad = 0;

  clusterv_sram_arb #(.AW(8), .DW(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .t0_adr(t0_adr), .t0_dat_w(t0_dat_w), .t0_sel(t0_sel), .t0_we(t0_we),
    .t0_cyc(t0_cyc), .t0_stb(t0_stb), .t0_dat_r(t0_dat_r), .t0_ack(t0_ack),
    .t1_adr(t1_adr), .t1_dat_w(t1_dat_w), .t1_sel(t1_sel), .t1_we(t1_we),
    .t1_cyc(t1_cyc), .t1_stb(t1_stb), .t1_dat_r(t1_dat_r), .t1_ack(t1_ack),
    .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_byte_en(sram_byte_en), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: enables latched mid-cycle, applied at the rising edge, read data one cycle later
  logic        clr;
  logic        cap_re, cap_we;
  logic [7:0]  cap_a;
  logic [3:0]  cap_be;
  logic [31:0] cap_wd;
  logic [31:0] mem [0:255];

  always @(negedge clock) begin
    cap_re = sram_read_en;
    cap_we = sram_write_en;
    cap_a  = sram_addr;
    cap_be = sram_byte_en;
    cap_wd = sram_write_data;
  end

  always @(posedge clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      sram_read_data <= 32'h0;
    end else begin
      if (cap_we)
        for (int b = 0; b < 4; b++)
          if (cap_be[b]) mem[cap_a][b*8 +: 8] <= cap_wd[b*8 +: 8];
      if (cap_re) sram_read_data <= mem[cap_a];
    end
  end

  function automatic port_t P(input logic c, input logic s, input logic w,
                              input logic [31:0] a, input logic [3:0] l, input logic [31:0] d);
    return {c, s, w, a, l, d};
  endfunction

  function automatic outv_t E(input logic ren, input logic wen, input logic [7:0] addr,
                              input logic [3:0] be, input logic [31:0] wd,
                              input logic a0, input logic a1,
                              input logic [31:0] d0, input logic [31:0] d1);
    return {ren, wen, addr, be, wd, a0, a1, d0, d1};
  endfunction

  task automatic drive(input port_t a, input port_t b);
    t0_cyc = a.cyc; t0_stb = a.stb; t0_we = a.we; t0_adr = a.adr; t0_sel = a.sel; t0_dat_w = a.dat;
    t1_cyc = b.cyc; t1_stb = b.stb; t1_we = b.we; t1_adr = b.adr; t1_sel = b.sel; t1_dat_w = b.dat;
  endtask

  task automatic check(input string name, input outv_t want);
    outv_t g;
    g = {sram_read_en, sram_write_en, sram_addr, sram_byte_en, sram_write_data,
         t0_ack, t1_ack, t0_dat_r, t1_dat_r};
    n_chk++;
    if (g !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, g, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(NP, NP);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  vec_t tbl[19];
  int   exp_order[4];
  int   order[$];
  int   first_owner;

  // Reference model state for random traffic
  port_t       pr[2];
  logic        hold[2];
  logic        rq[2];
  logic        ackv[2];
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata;
  int          en_cycle, ack_cycle, free_from, owner, m_last, win;

  initial begin
    automatic logic [31:0] A  = 32'h2000_0010;
    automatic logic [31:0] A2 = 32'h7654_3013;
    logic       ren, wen, a0, a1;
    logic [7:0] addr;
    logic [3:0] be;
    logic [31:0] wd, d0, d1;

    // Directed single-access, readback, byte write, ignored high address bits and abort
    tbl[0]  = '{P(1'b1,1'b1,1'b1,A,4'hF,32'hDEADBEEF), NP, ZERO};
    tbl[1]  = '{P(1'b1,1'b1,1'b1,A,4'hF,32'hDEADBEEF), NP,
                E(1'b0,1'b1,8'h04,4'hF,32'hDEADBEEF,1'b0,1'b0,32'h0,32'h0)};
    tbl[2]  = '{P(1'b1,1'b1,1'b1,A,4'hF,32'hDEADBEEF), NP,
                E(1'b0,1'b0,8'h00,4'h0,32'h0,1'b1,1'b0,32'h0,32'h0)};
    tbl[3]  = '{NP, P(1'b1,1'b1,1'b0,A,4'hF,32'h0), ZERO};
    tbl[4]  = '{NP, P(1'b1,1'b1,1'b0,A,4'hF,32'h0),
                E(1'b1,1'b0,8'h04,4'hF,32'h0,1'b0,1'b0,32'h0,32'h0)};
    tbl[5]  = '{NP, P(1'b1,1'b1,1'b0,A,4'hF,32'h0),
                E(1'b0,1'b0,8'h00,4'h0,32'h0,1'b0,1'b1,32'h0,32'hDEADBEEF)};
    tbl[6]  = '{P(1'b1,1'b1,1'b1,A,4'b0010,32'h0000AB00), NP, ZERO};
    tbl[7]  = '{P(1'b1,1'b1,1'b1,A,4'b0010,32'h0000AB00), NP,
                E(1'b0,1'b1,8'h04,4'b0010,32'h0000AB00,1'b0,1'b0,32'h0,32'h0)};
    tbl[8]  = '{P(1'b1,1'b1,1'b1,A,4'b0010,32'h0000AB00), NP,
                E(1'b0,1'b0,8'h00,4'h0,32'h0,1'b1,1'b0,32'hDEADBEEF,32'h0)};
    tbl[9]  = '{NP, P(1'b1,1'b1,1'b0,A2,4'hF,32'h0), ZERO};
    tbl[10] = '{NP, P(1'b1,1'b1,1'b0,A2,4'hF,32'h0),
                E(1'b1,1'b0,8'h04,4'hF,32'h0,1'b0,1'b0,32'h0,32'h0)};
    tbl[11] = '{NP, P(1'b1,1'b1,1'b0,A2,4'hF,32'h0),
                E(1'b0,1'b0,8'h00,4'h0,32'h0,1'b0,1'b1,32'h0,32'hDEADABEF)};
    tbl[12] = '{NP, P(1'b1,1'b1,1'b0,A,4'hF,32'h0), ZERO};
    tbl[13] = '{NP, P(1'b1,1'b0,1'b0,A,4'hF,32'h0), ZERO};
    tbl[14] = '{P(1'b1,1'b1,1'b0,A,4'h3,32'h0), NP, ZERO};
    tbl[15] = '{P(1'b1,1'b1,1'b0,A,4'h3,32'h0), NP,
                E(1'b1,1'b0,8'h04,4'h3,32'h0,1'b0,1'b0,32'h0,32'h0)};
    tbl[16] = '{P(1'b1,1'b1,1'b0,A,4'h3,32'h0), NP,
                E(1'b0,1'b0,8'h00,4'h0,32'h0,1'b1,1'b0,32'hDEADABEF,32'h0)};
    tbl[17] = '{NP, NP, ZERO};
    tbl[18] = '{NP, NP, ZERO};

`ifdef CLUSTERV_SRAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    clr = 1'b1;
    reset_n = 1'b0;
    drive(NP, NP);
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", ZERO);
    clr = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].p0, tbl[i].p1);
      #3;
      check($sformatf("row%0d", i), tbl[i].exp);
      tick();
    end

    // Both ports requesting continuously from reset
    do_reset();
    drive(P(1'b1,1'b1,1'b1,32'h100,4'hF,32'h1111_1111), P(1'b1,1'b1,1'b1,32'h104,4'hF,32'h2222_2222));
    for (int c = 0; c < 16 && order.size() < 4; c++) begin
      #3;
      if (t0_ack) order.push_back(0);
      if (t1_ack) order.push_back(1);
      tick();
    end
    check_int("contend_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check_int($sformatf("contend_grant%0d", i), order[i], exp_order[i]);
    drive(NP, NP);
    tick();

    // Reset asserted in the ACK cycle of a port 0 access
    do_reset();
    drive(P(1'b1,1'b1,1'b1,32'h108,4'hF,32'h3333_3333), NP);
    #3; check("mr_idle", ZERO); tick();
    #3; check("mr_access", E(1'b0,1'b1,8'h42,4'hF,32'h3333_3333,1'b0,1'b0,32'h0,32'h0)); tick();
    #3; check("mr_ack", E(1'b0,1'b0,8'h00,4'h0,32'h0,1'b1,1'b0,32'hDEADABEF,32'h0));
    #2; reset_n = 1'b0;
    #1; check("mr_async", ZERO);
    drive(NP, NP);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3; check($sformatf("mr_quiet%0d", c), ZERO); tick();
    end
    drive(P(1'b1,1'b1,1'b1,32'h108,4'hF,32'h4444_4444), P(1'b1,1'b1,1'b1,32'h10C,4'hF,32'h5555_5555));
    first_owner = -1;
    for (int c = 0; c < 8 && first_owner < 0; c++) begin
      #3;
      if (t0_ack) first_owner = 0;
      else if (t1_ack) first_owner = 1;
      tick();
    end
    check_int("mr_first_grant", first_owner, 0);
    drive(NP, NP);
    tick();

    // Random traffic against the timeline model
    do_reset();
    en_cycle = -10; ack_cycle = -10; free_from = 0; owner = 0; m_last = 1;
    ref_rdata = 32'hDEADABEF;
    pr[0] = NP; pr[1] = NP; hold[0] = 1'b0; hold[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      drive(pr[0], pr[1]);
      #3;
      rq[0] = pr[0].cyc & pr[0].stb;
      rq[1] = pr[1].cyc & pr[1].stb;
      ren = 1'b0; wen = 1'b0; addr = 8'h0; be = 4'h0; wd = 32'h0;
      a0 = 1'b0; a1 = 1'b0; d0 = 32'h0; d1 = 32'h0;
      if (c == en_cycle && rq[owner]) begin
        ren  = ~pr[owner].we;
        wen  = pr[owner].we;
        addr = pr[owner].adr[9:2];
        be   = pr[owner].sel;
        wd   = pr[owner].dat;
      end
      if (c == ack_cycle) begin
        if (owner == 0) begin a0 = 1'b1; d0 = ref_rdata; end
        else            begin a1 = 1'b1; d1 = ref_rdata; end
      end
      check($sformatf("rand_c%0d", c), E(ren, wen, addr, be, wd, a0, a1, d0, d1));

      if (c == en_cycle) begin
        if (rq[owner]) begin
          ack_cycle = c + 1;
          if (pr[owner].we) begin
            for (int b = 0; b < 4; b++)
              if (pr[owner].sel[b]) ref_mem[pr[owner].adr[9:2]][b*8 +: 8] = pr[owner].dat[b*8 +: 8];
          end else begin
            ref_rdata = ref_mem[pr[owner].adr[9:2]];
          end
        end else begin
          free_from = c + 1;
        end
      end
      if (c >= free_from && (rq[0] || rq[1])) begin
`ifdef CLUSTERV_SRAM_ARB_FIXED_PRIO_EN
        win = rq[0] ? 0 : 1;
`else
        win = (rq[0] && rq[1]) ? (1 - m_last) : (rq[0] ? 0 : 1);
`endif
        owner = win;
        m_last = win;
        en_cycle = c + 1;
        free_from = c + 3;
      end

      ackv[0] = t0_ack;
      ackv[1] = t1_ack;
      for (int i = 0; i < 2; i++) begin
        if (hold[i]) begin
          if (ackv[i] || $urandom_range(0, 23) == 0) begin
            hold[i] = 1'b0;
            pr[i] = NP;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          hold[i] = 1'b1;
          pr[i] = P(1'b1, 1'b1, 1'($urandom_range(0, 1)),
                    ($urandom() & 32'hFFFF_FC03) | ((32'h10 + 32'($urandom_range(0, 15))) << 2),
                    4'($urandom()), $urandom());
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
